// File: rtl/ram_arbiter.sv
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Two-port round-robin arbiter in front of a single-port RAM with a
//            registered read output. Optional power-up clear: INIT_CLEAR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = '1;

`ifdef INIT_CLEAR_EN
    localparam state_t C_RESET_STATE = S_CLEAR;
`else
    localparam state_t C_RESET_STATE = S_RUN;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_addr;
    logic [ADDR_W-1:0] w_clr_addr_nxt;
    logic              w_busy;
    logic              r_last1;     // 1 when port 1 won the most recent handshake
    logic              r_rd_pend0;
    logic              r_rd_pend1;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= C_RESET_STATE;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_busy         = 1'b0;
        if (r_state == S_CLEAR) begin
            w_busy         = 1'b1;
            w_clr_addr_nxt = r_clr_addr + 1'b1;
            if (r_clr_addr == C_LAST_ADDR) begin
                w_state_nxt = S_RUN;
            end
        end
    end

`ifdef INIT_CLEAR_EN
    assign busy = w_busy;
`else
    assign busy = 1'b0;
`endif

    // Ties go to the port that did not win last; busy blocks both grants.
    assign gnt0  = !w_busy && req0 && (!req1 || r_last1);
    assign gnt1  = !w_busy && req1 && (!req0 || !r_last1);
    assign rdata = ram_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_last1    <= 1'b1;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_data   <= '0;
            r_rd_pend0 <= 1'b0;
            r_rd_pend1 <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
        end else begin
            // RAM q lands one cycle after the command, so rvalid trails by two.
            r_rd_pend0 <= gnt0 && !we0;
            r_rd_pend1 <= gnt1 && !we1;
            rvalid0    <= r_rd_pend0;
            rvalid1    <= r_rd_pend1;
            if (w_busy) begin
                ram_we   <= 1'b1;
                ram_addr <= r_clr_addr;
                ram_data <= '0;
            end else if (gnt0) begin
                ram_we   <= we0;
                ram_addr <= addr0;
                ram_data <= wdata0;
                r_last1  <= 1'b0;
            end else if (gnt1) begin
                ram_we   <= we1;
                ram_addr <= addr1;
                ram_data <= wdata1;
                r_last1  <= 1'b1;
            end else begin
                ram_we   <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Self-checking bench for ram_arbiter with a behavioural RAM and a
//            read scoreboard. Covers the clear sequence when INIT_CLEAR_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

    localparam int DATA_W = 4;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clock;
    logic              resetn;
    logic              req0, req1, we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_we;
    logic [DATA_W-1:0] ram_q;
    logic              busy;

    ram_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .req0    (req0),
        .req1    (req1),
        .we0     (we0),
        .we1     (we1),
        .addr0   (addr0),
        .addr1   (addr1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .rvalid0 (rvalid0),
        .rvalid1 (rvalid1),
        .rdata   (rdata),
        .ram_addr(ram_addr),
        .ram_data(ram_data),
        .ram_we  (ram_we),
        .ram_q   (ram_q),
        .busy    (busy)
    );

    typedef struct {
        logic              r0, w0;
        logic [ADDR_W-1:0] a0;
        logic [DATA_W-1:0] d0;
        logic              r1, w1;
        logic [ADDR_W-1:0] a1;
        logic [DATA_W-1:0] d1;
        logic              g0, g1;
    } vec_t;

    typedef struct {
        int                port;
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    int                checks   = 0;
    int                failures = 0;
    int                cyc      = 0;
    logic [DATA_W-1:0] mem    [DEPTH];
    logic [DATA_W-1:0] shadow [DEPTH];
    exp_t              sbq    [$];
    vec_t              vt     [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic vec_t mk(input logic r0, input logic w0, input logic [3:0] a0,
                                input logic [3:0] d0, input logic r1, input logic w1,
                                input logic [3:0] a1, input logic [3:0] d1,
                                input logic g0, input logic g1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1;
        return v;
    endfunction

    task automatic drive_idle();
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ram_we"},   ram_we,   0);
        check({tag, "_ram_addr"}, ram_addr, 0);
        check({tag, "_ram_data"}, ram_data, 0);
        check({tag, "_rvalid0"},  rvalid0,  0);
        check({tag, "_rvalid1"},  rvalid1,  0);
`ifdef INIT_CLEAR_EN
        check({tag, "_busy"},     busy,     1);
`else
        check({tag, "_busy"},     busy,     0);
`endif
    endtask

    // Release reset; with the clear feature, wait (bounded) for busy to drop.
    task automatic release_reset();
        @(posedge clock); #1;
        resetn = 1;
`ifdef INIT_CLEAR_EN
        @(negedge clock);
        @(negedge clock);
        check("clear_restart_addr", ram_addr, 0);
        for (int k = 0; k < 40 && busy; k++) @(negedge clock);
        check("busy_timeout", busy, 0);
`endif
    endtask

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Behavioural single-port RAM with registered q.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
`ifdef INIT_CLEAR_EN
            mem[i] = DATA_W'(i ^ 5);
`else
            mem[i] = '0;
`endif
            shadow[i] = '0;
        end
        ram_q = '0;
        forever begin
            logic [DATA_W-1:0] q_next;
            @(posedge clock);
            q_next = mem[ram_addr];
            if (ram_we) mem[ram_addr] = ram_data;
            ram_q <= q_next;
        end
    end

    // Monitor: protocol invariants, RAM command tracking and read scoreboard.
    initial begin
        logic              p_valid, p_hs, p_we;
        logic [ADDR_W-1:0] p_addr, last_addr;
        logic [DATA_W-1:0] p_data, last_data;
        exp_t              e;
        p_valid = 0; p_hs = 0; p_we = 0;
        p_addr = '0; p_data = '0; last_addr = '0; last_data = '0;
        forever begin
            @(negedge clock);
            if (!resetn) begin
                sbq.delete();
                p_valid = 0;
`ifdef INIT_CLEAR_EN
                for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
`endif
            end else begin
                check("gnt_mutex", gnt0 & gnt1, 0);
                if (busy) check("gnt_while_busy", gnt0 | gnt1, 0);
                if (p_valid) begin
                    if (p_hs) begin
                        check("cmd_we",   ram_we,   p_we);
                        check("cmd_addr", ram_addr, p_addr);
                        check("cmd_data", ram_data, p_data);
                    end else begin
                        check("idle_we",        ram_we,   0);
                        check("idle_addr_hold", ram_addr, last_addr);
                        check("idle_data_hold", ram_data, last_data);
                    end
                end
                if (sbq.size() > 0 && sbq[0].due == cyc) begin
                    e = sbq.pop_front();
                    check("rvalid0", rvalid0, (e.port == 0) ? 1 : 0);
                    check("rvalid1", rvalid1, (e.port == 1) ? 1 : 0);
                    check("rdata",   rdata,   e.data);
                end else if (rvalid0 || rvalid1) begin
                    check("unexpected_rvalid", {rvalid0, rvalid1}, 0);
                end
                last_addr = ram_addr;
                last_data = ram_data;
                p_valid   = !busy;
                p_hs      = 0;
                if (gnt0) begin
                    p_hs = 1; p_we = we0; p_addr = addr0; p_data = wdata0;
                    if (we0) shadow[addr0] = wdata0;
                    else     sbq.push_back('{0, shadow[addr0], cyc + 2});
                end else if (gnt1) begin
                    p_hs = 1; p_we = we1; p_addr = addr1; p_data = wdata1;
                    if (we1) shadow[addr1] = wdata1;
                    else     sbq.push_back('{1, shadow[addr1], cyc + 2});
                end
            end
        end
    end

    initial begin
        int nbusy, first_g;

        //        r0 w0 a0    d0    r1 w1 a1    d1    g0 g1
        vt[0]  = mk(1, 1, 4'h3, 4'hA, 1, 1, 4'h0, 4'h1, 1, 0);
        vt[1]  = mk(1, 1, 4'h6, 4'h9, 1, 1, 4'h0, 4'h1, 0, 1);
        vt[2]  = mk(1, 1, 4'h6, 4'h9, 1, 1, 4'h1, 4'h2, 1, 0);
        vt[3]  = mk(1, 0, 4'h3, 4'h0, 1, 1, 4'h1, 4'h2, 0, 1);
        vt[4]  = mk(0, 0, 4'h0, 4'h0, 1, 1, 4'h2, 4'h3, 0, 1);
        vt[5]  = mk(1, 0, 4'h3, 4'h0, 0, 0, 4'h0, 4'h0, 1, 0);
        vt[6]  = mk(0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 4'h0, 0, 1);
        vt[7]  = mk(0, 0, 4'h0, 4'h0, 1, 0, 4'h1, 4'h0, 0, 1);
        vt[8]  = mk(0, 0, 4'h0, 4'h0, 1, 0, 4'h2, 4'h0, 0, 1);
        vt[9]  = mk(1, 1, 4'h7, 4'h5, 0, 0, 4'h0, 4'h0, 1, 0);
        vt[10] = mk(0, 0, 4'h0, 4'h0, 1, 0, 4'h7, 4'h0, 0, 1);
        vt[11] = mk(1, 0, 4'h6, 4'h0, 1, 0, 4'h7, 4'h0, 1, 0);
        vt[12] = mk(0, 0, 4'h0, 4'h0, 1, 0, 4'h7, 4'h0, 0, 1);
        vt[13] = mk(0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0);
        vt[14] = mk(1, 0, 4'h0, 4'h0, 1, 1, 4'hF, 4'hF, 1, 0);
        vt[15] = mk(0, 0, 4'h0, 4'h0, 1, 1, 4'hF, 4'hF, 0, 1);
        vt[16] = mk(1, 0, 4'hF, 4'h0, 0, 0, 4'h0, 4'h0, 1, 0);

        resetn = 0;
        drive_idle();
`ifdef INIT_CLEAR_EN
        req0 = 1; addr0 = 4'h9;
`endif
        repeat (2) @(negedge clock);
        check_reset_vals("reset");

`ifdef INIT_CLEAR_EN
        @(posedge clock); #1;
        resetn  = 1;
        nbusy   = 0;
        first_g = -1;
        for (int n = 0; n < 40 && first_g < 0; n++) begin
            @(negedge clock);
            if (busy) nbusy++;
            if (n >= 1 && n <= 16) begin
                check("clear_we",   ram_we,   1);
                check("clear_addr", ram_addr, n - 1);
                check("clear_data", ram_data, 0);
            end
            if (gnt0) first_g = n;
        end
        check("clear_busy_cycles", nbusy,   16);
        check("clear_first_gnt",   first_g, 16);
        @(posedge clock); #1;
        drive_idle();
        repeat (4) @(negedge clock);
        @(posedge clock); #1;
        resetn = 0;
        @(negedge clock);
        check_reset_vals("rereset");
        release_reset();
`else
        release_reset();
`endif

        for (int i = 0; i < 17; i++) begin
            @(posedge clock); #1;
            req0 = vt[i].r0; we0 = vt[i].w0; addr0 = vt[i].a0; wdata0 = vt[i].d0;
            req1 = vt[i].r1; we1 = vt[i].w1; addr1 = vt[i].a1; wdata1 = vt[i].d1;
            @(negedge clock);
            check($sformatf("vec%0d_gnt0", i), gnt0, vt[i].g0);
            check($sformatf("vec%0d_gnt1", i), gnt1, vt[i].g1);
        end
        @(posedge clock); #1;
        drive_idle();
        repeat (4) @(negedge clock);

        // Reset one cycle after a read handshake: the read must vanish.
        @(posedge clock); #1;
        req0 = 1; we0 = 0; addr0 = 4'h3;
        @(negedge clock);
        check("midrst_gnt0", gnt0, 1);
        @(posedge clock); #1;
        drive_idle();
        resetn = 0;
        @(negedge clock);
        check_reset_vals("midrst");
        release_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("midrst_no_rvalid", rvalid0 | rvalid1, 0);
        end

        // Pointer must be back at port 1 so port 0 wins the first contest.
        @(posedge clock); #1;
        req0 = 1; addr0 = 4'h6; req1 = 1; addr1 = 4'h7;
        @(negedge clock);
        check("post_rst_gnt0", gnt0, 1);
        check("post_rst_gnt1", gnt1, 0);
        @(posedge clock); #1;
        req0 = 0;
        @(negedge clock);
        check("post_rst_gnt1_next", gnt1, 1);
        @(posedge clock); #1;
        drive_idle();
        repeat (5) @(negedge clock);

        check("sb_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
